// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words, writes them
// to consecutive word addresses and holds the CPU in reset until the load completes.
module imem_loader #(
  parameter int unsigned DEPTH_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [DEPTH_W:0]   load_len,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               im_we,
  output logic [31:0]        im_addr,
  output logic [31:0]        im_wdata,
  output logic               cpu_rst,
  output logic               load_done,
  output logic [31:0]        checksum
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StWrite   = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  localparam logic [DEPTH_W:0]   MaxLen = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [DEPTH_W:0]   LenOne = {{DEPTH_W{1'b0}}, 1'b1};
  localparam logic [DEPTH_W-1:0] IdxOne = {{(DEPTH_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [DEPTH_W:0]   len_q, len_d;
  logic [DEPTH_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [31:0]        word_q, word_d;
  logic [31:0]        im_addr_q, im_addr_d;
  logic [31:0]        im_wdata_q, im_wdata_d;
  logic [31:0]        checksum_q, checksum_d;
  logic               in_ready_q, in_ready_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               load_done_q, load_done_d;

  logic start_ok;
  logic accept;
  logic last_word;

  assign start_ok  = load_start && (load_len != '0) && (load_len <= MaxLen);
  assign accept    = in_valid && in_ready_q;
  assign last_word = ({1'b0, word_idx_q} == (len_q - LenOne));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    checksum_d = checksum_q;

    case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          len_d      = load_len;
          word_idx_d = '0;
          byte_cnt_d = '0;
          checksum_d = '0;
          state_d    = StCollect;
        end
      end
      StCollect: begin
        if (accept) begin
          word_d     = {word_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Address and data are captured here so they are stable during the write
          // cycle and simply hold afterwards.
          if (byte_cnt_q == 2'd3) begin
            state_d    = StWrite;
            im_addr_d  = {{(30 - DEPTH_W){1'b0}}, word_idx_q, 2'b00};
            im_wdata_d = {word_q[23:0], in_data};
          end
        end
      end
      StWrite: begin
        checksum_d = checksum_q ^ im_wdata_q;
        if (last_word) begin
          state_d = StDone;
        end else begin
          word_idx_d = word_idx_q + IdxOne;
          state_d    = StCollect;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d  = (state_d == StCollect);
    cpu_rst_d   = (state_d != StDone);
    load_done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      checksum_q  <= '0;
      in_ready_q  <= 1'b0;
      cpu_rst_q   <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      checksum_q  <= checksum_d;
      in_ready_q  <= in_ready_d;
      cpu_rst_q   <= cpu_rst_d;
      load_done_q <= load_done_d;
    end
  end

  assign im_we     = (state_q == StWrite);
  assign im_addr   = im_addr_q;
  assign im_wdata  = im_wdata_q;
  assign checksum  = checksum_q;
  assign in_ready  = in_ready_q;
  assign cpu_rst   = cpu_rst_q;
  assign load_done = load_done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random byte streams, expected writes queued per word and checked
// by an independent monitor whenever im_we fires.
module tb_imem_loader;

  localparam int unsigned DepthW = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic [DepthW:0]   load_len = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              im_we;
  logic [31:0]       im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic [31:0]       checksum;

  imem_loader #(.DEPTH_W(DepthW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          stalls   = 0;
  logic        tog      = 1'b0;
  logic [31:0] exp_csum = '0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] mon_last_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected word.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", im_addr,
                 im_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", im_addr, mon_e[63:32]);
        check("write_data", im_wdata, mon_e[31:0]);
        check("in_ready_during_write", {31'b0, in_ready}, 32'd0);
      end
      mon_last_addr = im_addr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; load_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_im_we", {31'b0, im_we}, 32'd0);
    check("rst_im_addr", im_addr, 32'd0);
    check("rst_im_wdata", im_wdata, 32'd0);
    check("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("rst_load_done", {31'b0, load_done}, 32'd0);
    check("rst_checksum", checksum, 32'd0);
    rst = 1'b0;
  endtask

  task automatic begin_load(input int len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = len[DepthW:0];
    @(posedge clk);
    #1;
    load_start = 1'b0;
    exp_csum   = '0;
    stalls     = 0;
    check("start_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("start_load_done", {31'b0, load_done}, 32'd0);
    check("start_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int mode);
    bit done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      in_data = b;
      case (mode)
        0: in_valid = 1'b1;
        1: begin tog = ~tog; in_valid = tog; end
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      if (in_valid && in_ready) done = 1'b1;
      else if (in_valid) stalls++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept_timeout: got no in_ready expected acceptance");
    end
  endtask

  task automatic push_word(input int idx, input logic [31:0] w);
    logic [31:0] a;
    a = idx * 4;
    exp_q.push_back({a, w});
    exp_csum ^= w;
  endtask

  task automatic send_bytes(input logic [31:0] w, input int first, input int last,
                            input int mode);
    for (int k = first; k <= last; k++) send_byte(w[31 - 8 * k -: 8], mode);
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input int mode);
    push_word(idx, w);
    send_bytes(w, 0, 3, mode);
  endtask

  task automatic finish_load(input int len, input int mode);
    @(negedge clk);
    in_valid = 1'b0;
    check("last_write_we", {31'b0, im_we}, 32'd1);
    check("cpu_rst_during_last_write", {31'b0, cpu_rst}, 32'd1);
    @(negedge clk);
    check("done_cpu_rst", {31'b0, cpu_rst}, 32'd0);
    check("done_load_done", {31'b0, load_done}, 32'd1);
    check("done_checksum", checksum, exp_csum);
    check("done_queue_empty", exp_q.size(), 32'd0);
    if (mode == 0) check("ready_bubbles", stalls, len - 1);
  endtask

  task automatic run_load(input int len, input int mode);
    begin_load(len);
    for (int i = 0; i < len; i++) send_word(i, $urandom, mode);
    finish_load(len, mode);
  endtask

  task automatic pulse_invalid(input int len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = len[DepthW:0];
    @(negedge clk);
    load_start = 1'b0;
  endtask

  logic [31:0] w0;

  initial begin
    // 1) single word, known bytes
    do_reset();
    begin_load(1);
    send_word(0, 32'h8C01_0004, 0);
    finish_load(1, 0);
    check("t1_checksum", checksum, 32'h8C01_0004);

    // invalid start in DONE is ignored
    pulse_invalid(0);
    check("done_hold_load_done", {31'b0, load_done}, 32'd1);
    check("done_hold_cpu_rst", {31'b0, cpu_rst}, 32'd0);

    // 2) three words, gap-free, restarted from DONE
    run_load(3, 0);

    // 3) two words, in_valid toggling
    run_load(2, 1);

    // 4) ignored starts in IDLE, then a start mid-COLLECT
    do_reset();
    pulse_invalid(0);
    check("len0_in_ready", {31'b0, in_ready}, 32'd0);
    check("len0_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    pulse_invalid(65);
    @(negedge clk);
    check("len65_in_ready", {31'b0, in_ready}, 32'd0);
    check("len65_load_done", {31'b0, load_done}, 32'd0);
    begin_load(2);
    w0 = $urandom;
    push_word(0, w0);
    send_bytes(w0, 0, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    load_start = 1'b1;
    load_len = 7'd1;
    @(negedge clk);
    load_start = 1'b0;
    check("mid_start_in_ready", {31'b0, in_ready}, 32'd1);
    send_bytes(w0, 2, 3, 0);
    send_word(1, $urandom, 0);
    finish_load(2, 0);

    // 5) reset after six bytes of a four-word load
    begin_load(4);
    send_word(0, $urandom, 0);
    send_bytes($urandom, 0, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("abort_checksum", checksum, 32'd0);
    check("abort_im_we", {31'b0, im_we}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd0);
    check("abort_load_done", {31'b0, load_done}, 32'd0);
    rst = 1'b0;
    run_load(1, 0);

    // 6) full depth with random gaps
    run_load(64, 2);
    check("full_last_addr", mon_last_addr, 32'h0000_00FC);
    repeat (5) @(negedge clk);
    check("full_still_done", {31'b0, load_done}, 32'd1);

    // random short loads
    for (int r = 0; r < 4; r++) run_load($urandom_range(1, 8), $urandom_range(0, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
